rr_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one multiplexer4 instance between four requesters.
- Drives the mux `select` and a one-hot grant vector, and enforces a maximum hold time so no requester can monopolise the bus.
- Sits between the four bus masters and the 4:1 mux that feeds the shared downstream bus.

---
 rtl/rr_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for four masters sharing one 4:1 bus mux, with a cap
// on how many back-to-back cycles one master may hold the bus.
// Ports: clk, reset (async, active high), req[3:0] in;
//        grant[3:0] one-hot, select[1:0] mux index,
//        bus_valid, owner_changed (1-cycle pulse) out.
module rr_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       bus_valid,
  output logic       owner_changed
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;

  logic [1:0] base;
  logic       found;
  logic [1:0] win;
  logic       rel;

  // Search starts just after 'last'; 'last' itself is checked last.
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] last
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;

    // On release the current owner becomes last_owner for this search.
    base         = (state_q == GRANT) ? sel_q : last_q;
    {found, win} = rr_pick(req, base);
    rel          = !req[sel_q] || (cnt_q == HOLD_LAST);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = 4'b0001 << win;
          sel_d   = win;
          valid_d = 1'b1;
          chg_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          last_d = sel_q;
          if (found) begin
            grant_d = 4'b0001 << win;
            sel_d   = win;
            chg_d   = (win != sel_q);
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign grant         = grant_q;
  assign select        = sel_q;
  assign bus_valid     = valid_q;
  assign owner_changed = chg_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: vector table, corner sequences,
// and random traffic against a cycle-level reference model.
module tb_rr_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req1;
  logic [3:0] grant, grant1;
  logic [1:0] select, select1;
  logic       bus_valid, bus_valid1;
  logic       owner_changed, owner_changed1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant), .select(select),
    .bus_valid(bus_valid), .owner_changed(owner_changed)
  );

  rr_bus_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .req(req1),
    .grant(grant1), .select(select1),
    .bus_valid(bus_valid1), .owner_changed(owner_changed1)
  );

  // Reference model: owner index (-1 = idle), cycles owned so far.
  int m_owner, m_last, m_held, m_sel, m_chg;
  localparam int MH = 8;

  function automatic int first_req(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_last = 3; m_held = 0; m_sel = 0; m_chg = 0;
  endtask

  task automatic m_step(input logic [3:0] r);
    int w;
    m_chg = 0;
    if (m_owner < 0) begin
      w = first_req(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_held = 1; m_chg = 1;
      end
    end else if (r[m_owner] && m_held < MH) begin
      m_held++;
    end else begin
      m_last = m_owner;
      w = first_req(r, m_last);
      if (w >= 0) begin
        m_chg = (w != m_owner) ? 1 : 0;
        m_owner = w; m_sel = w; m_held = 1;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] eg,
                     input logic [1:0] es, input logic ev, input logic ec);
    n_tests++;
    if (grant !== eg || select !== es || bus_valid !== ev ||
        owner_changed !== ec) begin
      n_fail++;
      $display("FAIL %s: got g=%b s=%0d v=%b c=%b want g=%b s=%0d v=%b c=%b",
               nm, grant, select, bus_valid, owner_changed, eg, es, ev, ec);
    end
  endtask

  task automatic chk_model(input string nm);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk(nm, eg, 2'(m_sel), (m_owner >= 0), 1'(m_chg));
  endtask

  // Apply req for one edge, then check against the model just after it.
  task automatic cyc(input logic [3:0] r, input string nm);
    req = r;
    @(posedge clk);
    #1;
    m_step(r);
    chk_model(nm);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; req1 = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       c;
  } vec_t;

  vec_t vt[12];
  int   pulses;
  logic [3:0] rot_exp [5];
  int   rot_at [5];
  int   ri;
  logic [3:0] rr;

  initial begin
    reset = 1'b1; req = 4'b0; req1 = 4'b0;
    m_reset();

    // Test 2 then test 4 as a fixed table (continuous, no reset between).
    vt[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vt[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vt[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vt[5]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vt[6]  = '{4'b0111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[7]  = '{4'b0111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[8]  = '{4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1};
    vt[9]  = '{4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    vt[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = vt[i].r;
      @(posedge clk);
      #1;
      m_step(vt[i].r);
      chk($sformatf("vec%0d", i), vt[i].g, vt[i].s, vt[i].v, vt[i].c);
    end

    // Test 1: all request, rotation with 8-cycle holds.
    do_reset();
    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;
    for (int i = 0; i < 5; i++) rot_at[i] = 1 + 8 * i;
    pulses = 0; ri = 0;
    for (int c = 1; c <= 36; c++) begin
      cyc(4'b1111, "rot_model");
      if (owner_changed) pulses++;
      if (ri < 5 && c == rot_at[ri]) begin
        chk($sformatf("rot_hand%0d", ri), rot_exp[ri], 2'(ri % 4), 1'b1, 1'b1);
        ri++;
      end
    end
    n_tests++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL rot_pulses: got %0d want 5", pulses);
    end

    // Test 3: sole requester, forced re-grant to itself.
    do_reset();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(4'b0001, "sole_model");
      if (grant !== 4'b0001) begin
        n_tests++; n_fail++;
        $display("FAIL sole_grant: got %b want 0001 at cycle %0d", grant, c);
      end
      if (owner_changed) pulses++;
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL sole_pulses: got %0d want 1", pulses);
    end

    // Test 5: async reset in the middle of a grant to requester 3.
    do_reset();
    cyc(4'b1000, "pre_async");
    chk("grant3", 4'b1000, 2'd3, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    m_reset();
    cyc(4'b1001, "post_async_model");
    chk("post_async", 4'b0001, 2'd0, 1'b1, 1'b1);
    req = 4'b0000;

    // Test 6: MAX_HOLD=1 instance alternates every cycle.
    do_reset();
    req1 = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (grant1 !== ((c % 2 == 0) ? 4'b0010 : 4'b1000) ||
          select1 !== ((c % 2 == 0) ? 2'd1 : 2'd3) ||
          bus_valid1 !== 1'b1 || owner_changed1 !== 1'b1) begin
        n_fail++;
        $display("FAIL mh1_c%0d: got g=%b s=%0d v=%b c=%b", c,
                 grant1, select1, bus_valid1, owner_changed1);
      end
    end
    req1 = 4'b0000;

    // Random traffic with sticky requests so holds reach the cap.
    do_reset();
    rr = 4'b0000;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      cyc(rr, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
